// File: rtl/pipe_clock_ctrl_pkg.sv
// Shared mode/state encodings for the pipeline clock-enable controller.
package pipe_clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeHalt = 2'b00,
        ModeRun  = 2'b01,
        ModeStep = 2'b10,
        ModeFree = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StHalt  = 2'b00,
        StRun   = 2'b01,
        StBreak = 2'b10,
        StFree  = 2'b11
    } state_e;

    localparam int unsigned TickCountWidth = 32;

    // States in which a debounced step press is allowed to issue a tick.
    function automatic logic steppable(state_e s);
        return (s == StHalt) || (s == StBreak);
    endfunction

endpackage

// File: rtl/pipe_clock_ctrl_btn_debounce.sv
// Step-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge detect producing a one-cycle press pulse.
module pipe_clock_ctrl_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            press_q;
    logic [CntW-1:0] cnt_q;

    // cnt_q counts consecutive synchronised samples that disagree with level_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pipe_clock_ctrl.sv
// Pipeline clock-enable / run controller: loadable divider, HALT/RUN/BREAK/FREE
// FSM, debounced single-step. Optional tick counter: PIPE_TICK_COUNTER_EN.
module pipe_clock_ctrl
    import pipe_clock_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned DEFAULT_DIV     = 10000000,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_LOCK,
    input  logic [1:0]           I_Mode,
    input  logic                 I_DivLoad,
    input  logic [CNT_WIDTH-1:0] I_DivValue,
    input  logic                 I_StepBtn,
    input  logic                 I_BreakHit,
    output logic                 O_Tick,
    output logic                 O_ClkSlow,
    output logic [1:0]           O_State,
    output logic                 O_Running,
    output logic [31:0]          O_TickCount
);

    mode_e                mode;
    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] div_q;
    logic [CNT_WIDTH-1:0] div_eff;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 div_event;
    logic                 press;
    logic                 tick_q;
    logic                 tick_d;
    logic                 slow_q;
    logic                 running_q;

    pipe_clock_ctrl_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (I_CLOCK),
        .rst  (I_RESET),
        .btn  (I_StepBtn),
        .press(press)
    );

    assign mode      = mode_e'(I_Mode);
    assign div_eff   = (div_q == '0) ? CNT_WIDTH'(1) : div_q;
    assign div_event = I_LOCK && !I_DivLoad && (cnt_q == div_eff - CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        if (I_LOCK) begin
            unique case (mode)
                ModeHalt, ModeStep: state_d = StHalt;
                ModeFree:           state_d = StFree;
                ModeRun: begin
                    // BREAK is only left by the mode moving away from RUN.
                    if (state_q == StBreak) begin
                        state_d = StBreak;
                    end else if (state_q == StRun && I_BreakHit) begin
                        state_d = StBreak;
                    end else begin
                        state_d = StRun;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (I_DivLoad || !I_LOCK || div_event) begin
            cnt_d = '0;
        end
    end

    assign tick_d = I_LOCK && ((state_q == StFree) ||
                               (state_q == StRun && div_event) ||
                               (press && steppable(state_q)));

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state_q   <= StHalt;
            div_q     <= CNT_WIDTH'(DEFAULT_DIV);
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            slow_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (I_DivLoad) begin
                div_q <= I_DivValue;
            end
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            slow_q    <= slow_q ^ tick_d;
            running_q <= (state_d == StRun) || (state_d == StFree);
        end
    end

    assign O_Tick    = tick_q;
    assign O_ClkSlow = slow_q;
    assign O_State   = state_q;
    assign O_Running = running_q;

`ifdef PIPE_TICK_COUNTER_EN
    logic [TickCountWidth-1:0] tick_count_q;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            tick_count_q <= '0;
        end else if (tick_q) begin
            tick_count_q <= tick_count_q + TickCountWidth'(1);
        end
    end

    assign O_TickCount = tick_count_q;
`else
    assign O_TickCount = '0;
`endif

endmodule

// File: tb/tb_pipe_clock_ctrl.sv
// Self-checking bench for pipe_clock_ctrl: directed scenarios plus random
// stimulus, compared cycle by cycle against a behavioural model.
module tb_pipe_clock_ctrl;

    localparam int unsigned DefDiv = 6;
    localparam int unsigned Deb    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        lock;
    logic [1:0]  mode;
    logic        div_load;
    logic [31:0] div_value;
    logic        btn;
    logic        brk;
    logic        tick;
    logic        slow;
    logic [1:0]  state;
    logic        running;
    logic [31:0] tick_count;

    int tests = 0;
    int fails = 0;

    // Behavioural model state (states: 0 HALT, 1 RUN, 2 BREAK, 3 FREE).
    int unsigned m_state, m_div, m_cnt, m_count;
    bit          m_tick, m_slow, m_press, m_level, m_run_val;
    bit          m_hist1, m_hist2;
    int          m_run;

    pipe_clock_ctrl #(
        .CNT_WIDTH      (32),
        .DEFAULT_DIV    (DefDiv),
        .DEBOUNCE_CYCLES(Deb)
    ) dut (
        .I_CLOCK    (clk),
        .I_RESET    (rst),
        .I_LOCK     (lock),
        .I_Mode     (mode),
        .I_DivLoad  (div_load),
        .I_DivValue (div_value),
        .I_StepBtn  (btn),
        .I_BreakHit (brk),
        .O_Tick     (tick),
        .O_ClkSlow  (slow),
        .O_State    (state),
        .O_Running  (running),
        .O_TickCount(tick_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        bit          ds, press_now, press_next, ev, tick_next;
        int unsigned eff;
        if (rst) begin
            m_state = 0; m_div = DefDiv; m_cnt = 0; m_count = 0;
            m_tick = 0; m_slow = 0; m_press = 0; m_level = 0;
            m_run_val = 0; m_run = 0; m_hist1 = 0; m_hist2 = 0;
            return;
        end
        // Button level seen by the debouncer is the raw sample from two edges back.
        ds = m_hist2;
        m_hist2 = m_hist1;
        m_hist1 = btn;
        press_now  = m_press;
        press_next = 0;
        if (ds == m_run_val) begin
            if (m_run < Deb) m_run++;
        end else begin
            m_run_val = ds;
            m_run = 1;
        end
        if (ds != m_level && m_run >= Deb) begin
            m_level = ds;
            press_next = ds;
        end

        eff = (m_div == 0) ? 1 : m_div;
        ev  = lock && !div_load && (m_cnt == eff - 1);
        tick_next = lock && (m_state == 3 || (m_state == 1 && ev) ||
                             (press_now && (m_state == 0 || m_state == 2)));
`ifdef PIPE_TICK_COUNTER_EN
        if (m_tick) m_count = m_count + 1;
`endif
        if (div_load || !lock || ev) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (div_load) m_div = div_value;
        if (lock) begin
            case (mode)
                2'b00, 2'b10: m_state = 0;
                2'b11:        m_state = 3;
                default: begin
                    if (m_state == 2) m_state = 2;
                    else if (m_state == 1 && brk) m_state = 2;
                    else m_state = 1;
                end
            endcase
        end
        m_tick  = tick_next;
        m_slow  = m_slow ^ tick_next;
        m_press = press_next;
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("tick", {31'b0, tick}, {31'b0, m_tick});
        check_eq("state", {30'b0, state}, m_state);
        check_eq("clk_slow", {31'b0, slow}, {31'b0, m_slow});
        check_eq("running", {31'b0, running}, {31'b0, (m_state == 1 || m_state == 3)});
        check_eq("tick_count", tick_count, m_count);
    endtask

    task automatic run(int n);
        repeat (n) tick_cycle();
    endtask

    task automatic run_count(int n, output int ticks);
        ticks = 0;
        repeat (n) begin
            tick_cycle();
            if (tick) ticks++;
        end
    endtask

    task automatic load_div(int unsigned v);
        div_value = v;
        div_load  = 1'b1;
        tick_cycle();
        div_load  = 1'b0;
    endtask

    initial begin
        int t, a, guard;
        rst = 1'b1; lock = 1'b1; mode = 2'b00; div_load = 1'b0;
        div_value = '0; btn = 1'b0; brk = 1'b0;
        run(3);
        rst = 1'b0;
        run(2);

        // Divide-by-4 in RUN: first event lands on the 4th edge after the load.
        load_div(4);
        mode = 2'b01;
        run_count(24, t);
        check_eq("ticks_div4", t, 6);

        // Divisors 0 and 1 both tick every cycle.
        load_div(0);
        run_count(10, t);
        check_eq("ticks_div0", t, 10);
        load_div(1);
        run_count(10, t);
        check_eq("ticks_div1", t, 10);

        // Breakpoint on a divider-event cycle, then single-step out of BREAK.
        load_div(3);
        guard = 0;
        while (m_cnt != 2 && guard < 10) begin
            tick_cycle();
            guard++;
        end
        check_eq("brk_align", {31'b0, (m_cnt == 2)}, 32'd1);
        brk = 1'b1;
        tick_cycle();
        brk = 1'b0;
        check_eq("brk_tick", {31'b0, tick}, 32'd1);
        check_eq("brk_state", {30'b0, state}, 32'd2);
        run_count(20, t);
        check_eq("ticks_in_break", t, 0);
        btn = 1'b1;
        run_count(40, t);
        btn = 1'b0;
        run_count(25, a);
        check_eq("ticks_break_step", t + a, 1);
        check_eq("break_state_kept", {30'b0, state}, 32'd2);

        // STEP mode with a bouncing button.
        mode = 2'b10;
        run(3);
        for (int i = 0; i < 5; i++) begin
            btn = ~btn;
            tick_cycle();
        end
        btn = 1'b1;
        run_count(40, t);
        check_eq("ticks_bouncy_press", t, 1);
        btn = 1'b0;
        run_count(30, t);
        btn = 1'b1;
        run_count(30, a);
        check_eq("ticks_second_press", t + a, 1);
        btn = 1'b0;
        run(25);

        // FREE with a 5-cycle PLL unlock.
        mode = 2'b11;
        run(5);
        lock = 1'b0;
        run_count(5, t);
        check_eq("ticks_unlocked", t, 0);
        lock = 1'b1;
        run_count(5, t);
        check_eq("ticks_relocked", t, 5);

        // Reset mid-RUN, then confirm the default divisor is back.
        mode = 2'b01;
        load_div(5);
        run(40);
        rst = 1'b1;
        tick_cycle();
        rst = 1'b0;
        check_eq("rst_state", {30'b0, state}, 32'd0);
        check_eq("rst_tick", {31'b0, tick}, 32'd0);
        check_eq("rst_count", tick_count, 32'd0);
        run_count(24, t);
        check_eq("ticks_default_div", t, 4);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            div_load  = ($urandom_range(0, 29) == 0);
            div_value = $urandom_range(0, 6);
            brk       = ($urandom_range(0, 24) == 0);
            lock      = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 11) == 0) btn = ~btn;
            rst       = ($urandom_range(0, 399) == 0);
            tick_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
